dual_port_mem_arbiter: RTL and testbench
========================================

// Module: dual_port_mem_arbiter
// PURPOSE
//  Shares one 4-bit x 8-word dual-port RAM among NREQ requesters. Up to two requests are
//  granted per cycle: one on port A, one on port B. Round-robin priority; same-address hazards
//  are blocked. Sits between requester masters and the RAM; drives its ports through
//  registers and routes registered read data back to the requester that issued the read.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  DW    4  data width; must match RAM word size
//  AW    3  address width; RAM depth = 2**AW = 8
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous reset, active-high
//  req        in   NREQ      request per requester; held until gnt
//  we         in   NREQ      1 = write, 0 = read; held with req
//  addr       in   NREQ*AW   addr of requester i at [i*AW +: AW]
//  wdata      in   NREQ*DW   write data of requester i at [i*DW +: DW]
//  gnt        out  NREQ      combinational accept pulse; request consumed at this clock edge
//  rvalid     out  NREQ      read-data valid pulse per requester
//  rdata      out  NREQ*DW   read data of requester i at [i*DW +: DW]; valid when rvalid[i]
//  mem_addr_a out  AW        RAM port A address (registered)
//  mem_data_a out  DW        RAM port A write data (registered)
//  mem_we_a   out  1         RAM port A write enable (registered)
//  mem_q_a    in   DW        RAM port A read data
//  mem_addr_b/mem_data_b/mem_we_b/mem_q_b: same as port A, for port B
//  conflict_cnt out 8        saturating count of cycles in which a hazard blocked a request
// BEHAVIOUR
//  Reset (async, immediate): gnt=0, rvalid=0, rdata=0, all mem_* outputs=0, rr_ptr=0,
//   conflict_cnt=0, in-flight read pipeline cleared. Reads in flight at reset never return.
//  Arbitration (combinational, cycle c):
//   - Scan requesters from rr_ptr upward, wrapping modulo NREQ.
//   - First requester with req=1 takes port A. Next eligible one takes port B.
//   - Eligible for B = req=1 and no hazard with the A winner.
//   - Hazard = equal addr AND at least one of the two is a write. Read-read to the same
//     address is allowed.
//   - A hazard-blocked requester is skipped; the scan continues to later requesters.
//   - gnt has at most 2 bits set.
//  rr_ptr update: if any grant, rr_ptr <= (index of last granted requester + 1) mod NREQ;
//   otherwise it holds.
//  Issue: at the edge ending c, port X registers latch addr/wdata/we of its winner.
//   A port with no winner gets mem_we_X=0; its addr/data hold their last value.
//   RAM samples in cycle c+1 and updates mem_q at the edge ending c+1 for reads; for writes
//   the RAM array is written at that edge and mem_q_X holds.
//  Return: in cycle c+1 register tag {valid, id} per port.
//   - At the edge ending c+1, tag shifts to stage 2.
//   - Cycle c+2: rvalid[id]=1 and rdata[id]=mem_q_X for each stage-2 read.
//   - Read latency: gnt to rvalid = 2 cycles. Writes produce no rvalid.
//  rdata[i] holds its last value when rvalid[i]=0. If both ports return to the same id,
//   that is impossible: one requester gets at most one grant per cycle.
//  Ordering: a write granted in cycle c is visible to a read granted in cycle c+1 or later.
//  conflict_cnt: +1 on any cycle where >=1 requesting requester was skipped due to hazard.
//   Saturates at 255.
//  Unused requesters (req=0) never affect the pointer or the counters.
// TESTING
//  1 Reset mid-read: grant read at c, assert rst at c+1 -> rvalid stays 0, all mem_we=0, rr_ptr=0.
//  2 Req0 write addr3=4'hA, req1 read addr5, next cycle req2 read addr3
//    -> gnt=0011 then 0100; rvalid[2] at +2 with rdata=4'hA.
//  3 Req0 write addr2, req1 write addr2, req2 read addr6 -> gnt=0101, conflict_cnt=1;
//    req1 is granted the next cycle (rr_ptr=3 wraps to 1).
//  4 All four reading addr7 (RAM=4'h5), rr_ptr=0 -> gnt 0011 then 1100;
//    rvalid 0011 then 1100, all rdata=4'h5.
//  5 Fairness: all req held continuously for 8 cycles -> each requester granted exactly 4 times.
//  6 Saturation: force 300 hazard cycles -> conflict_cnt=255 and holds.

Source files
------------

// File: rtl/dual_port_mem_arbiter.sv
// dual_port_mem_arbiter
// Shares one dual-port RAM among NREQ requesters. Each cycle a round-robin scan picks
// up to two winners: the first requester takes port A, and the next one with no address
// hazard against A takes port B. The winners are registered onto the RAM ports.
// Read tags travel through a two-stage pipeline so that the RAM output can be steered
// back to the requester that issued the read.
module dual_port_mem_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int AW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [NREQ*DW-1:0] rdata,
  output logic [AW-1:0]     mem_addr_a,
  output logic [DW-1:0]     mem_data_a,
  output logic              mem_we_a,
  input  logic [DW-1:0]     mem_q_a,
  output logic [AW-1:0]     mem_addr_b,
  output logic [DW-1:0]     mem_data_b,
  output logic              mem_we_b,
  input  logic [DW-1:0]     mem_q_b,
  output logic [7:0]        conflict_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Return-path tag: marks a read in flight on one port and names its requester.
  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } tag_t;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_next;
  logic          a_found;
  logic          b_found;
  logic [IW-1:0] a_idx;
  logic [IW-1:0] b_idx;
  logic          hazard_skip;
  tag_t          s1_a, s1_b, s2_a, s2_b;
  logic [DW-1:0] rdata_hold [NREQ];

  // Round-robin scan from rr_ptr that picks the port A and port B winners.
  always_comb begin
    int idx;
    int last;
    // NOTE: every output of this block gets a default before the loop, so no path
    // can leave one unassigned and infer a latch.
    gnt         = '0;
    a_found     = 1'b0;
    b_found     = 1'b0;
    a_idx       = '0;
    b_idx       = '0;
    hazard_skip = 1'b0;
    rr_next     = rr_ptr;
    idx         = 0;
    last        = 0;
    // NOTE: blocking assignments are required here. Each step of the scan reads the
    // found flags that the previous step wrote.
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx] && !rst) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = IW'(idx);
          last    = idx;
        end else if (!b_found) begin
          if ((addr[idx*AW +: AW] == addr[a_idx*AW +: AW]) && (we[idx] || we[a_idx])) begin
            hazard_skip = 1'b1;
          end else begin
            b_found = 1'b1;
            b_idx   = IW'(idx);
            last    = idx;
          end
        end
      end
    end
    if (a_found) gnt[a_idx] = 1'b1;
    if (b_found) gnt[b_idx] = 1'b1;
    if (a_found) rr_next = (last + 1 >= NREQ) ? '0 : IW'(last + 1);
  end

  // Pointer, RAM port registers, tag pipeline and the hazard counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      mem_addr_a   <= '0;
      mem_data_a   <= '0;
      mem_we_a     <= 1'b0;
      mem_addr_b   <= '0;
      mem_data_b   <= '0;
      mem_we_b     <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      s2_a         <= '0;
      s2_b         <= '0;
      conflict_cnt <= '0;
    end else begin
      rr_ptr   <= rr_next;
      mem_we_a <= a_found && we[a_idx];
      mem_we_b <= b_found && we[b_idx];
      if (a_found) begin
        mem_addr_a <= addr[a_idx*AW +: AW];
        mem_data_a <= wdata[a_idx*DW +: DW];
      end
      if (b_found) begin
        mem_addr_b <= addr[b_idx*AW +: AW];
        mem_data_b <= wdata[b_idx*DW +: DW];
      end
      s1_a <= '{valid: a_found && !we[a_idx], id: a_idx};
      s1_b <= '{valid: b_found && !we[b_idx], id: b_idx};
      s2_a <= s1_a;
      s2_b <= s1_b;
      if (hazard_skip && (conflict_cnt != 8'hFF)) conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

  // Steers the RAM outputs to the requesters named by the stage-2 tags. Requesters
  // with no returning read see their last returned value.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rdata[i*DW +: DW] = rdata_hold[i];
      if (s2_b.valid && (s2_b.id == IW'(i))) begin
        rvalid[i]         = 1'b1;
        rdata[i*DW +: DW] = mem_q_b;
      end
      if (s2_a.valid && (s2_a.id == IW'(i))) begin
        rvalid[i]         = 1'b1;
        rdata[i*DW +: DW] = mem_q_a;
      end
    end
  end

  // Captures each returned word so rdata holds its value between returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this register array is small and its value is visible on rdata, so it is
      // reset explicitly. A large storage array would normally be left unreset.
      for (int i = 0; i < NREQ; i++) rdata_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (rvalid[i]) rdata_hold[i] <= rdata[i*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Testbench for dual_port_mem_arbiter: a behavioural RAM, a reference model that
// predicts grants and RAM port registers, and a scoreboard monitor that checks read returns.
module tb_dual_port_mem_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int AW   = 3;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      we;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic [NREQ*DW-1:0]   rdata;
  logic [AW-1:0]        mem_addr_a, mem_addr_b;
  logic [DW-1:0]        mem_data_a, mem_data_b;
  logic                 mem_we_a, mem_we_b;
  logic [DW-1:0]        mem_q_a, mem_q_b;
  logic [7:0]           conflict_cnt;

  dual_port_mem_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a), .mem_we_a(mem_we_a), .mem_q_a(mem_q_a),
    .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b), .mem_we_b(mem_we_b), .mem_q_b(mem_q_b),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural synchronous dual-port RAM.
  logic [DW-1:0] ram [8];
  initial begin
    for (int i = 0; i < 8; i++) ram[i] = '0;
    mem_q_a = '0;
    mem_q_b = '0;
  end
  always @(posedge clk) begin
    if (mem_we_a) ram[mem_addr_a] <= mem_data_a; else mem_q_a <= ram[mem_addr_a];
    if (mem_we_b) ram[mem_addr_b] <= mem_data_b; else mem_q_b <= ram[mem_addr_b];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard shared by the model (which pushes) and the monitor (which pops).
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;
  rd_t exp_q [NREQ][$];

  // Reference model state.
  logic [DW-1:0] shadow [8];
  int            m_rr;
  int            m_cnt;
  logic          exp_we_a, exp_we_b;
  logic [AW-1:0] exp_addr_a, exp_addr_b;
  logic [DW-1:0] exp_data_a, exp_data_b;
  initial for (int i = 0; i < 8; i++) shadow[i] = '0;

  function automatic int addr_of(input int i);
    return int'(addr[i*AW +: AW]);
  endfunction

  function automatic bit clash(input int x, input int y);
    return (addr_of(x) == addr_of(y)) && (we[x] || we[y]);
  endfunction

  // Model: predicts grants, registered RAM port values and the hazard counter.
  always @(negedge clk) begin
    int            order[$];
    int            a, b, bpos;
    bit            skipped;
    logic [NREQ-1:0] eg;
    if (rst) begin
      check("gnt_in_reset", gnt, 0);
      m_rr = 0; m_cnt = 0;
      exp_we_a = 0; exp_we_b = 0;
      exp_addr_a = '0; exp_addr_b = '0;
      exp_data_a = '0; exp_data_b = '0;
    end else begin
      check("mem_we_a", mem_we_a, exp_we_a);
      check("mem_we_b", mem_we_b, exp_we_b);
      check("mem_addr_a", mem_addr_a, exp_addr_a);
      check("mem_addr_b", mem_addr_b, exp_addr_b);
      check("mem_data_a", mem_data_a, exp_data_a);
      check("mem_data_b", mem_data_b, exp_data_b);
      check("conflict_cnt", conflict_cnt, m_cnt);
      order = {};
      for (int k = 0; k < NREQ; k++) if (req[(m_rr + k) % NREQ]) order.push_back((m_rr + k) % NREQ);
      a = -1; b = -1; bpos = -1; skipped = 0; eg = '0;
      if (order.size() > 0) begin
        a = order.pop_front();
        foreach (order[j]) if (bpos < 0 && !clash(a, order[j])) bpos = j;
        if (bpos >= 0) b = order[bpos];
        skipped = (bpos > 0) || (bpos < 0 && order.size() > 0);
        eg[a] = 1'b1;
        if (b >= 0) eg[b] = 1'b1;
      end
      check("gnt", gnt, eg);
      exp_we_a = 0; exp_we_b = 0;
      if (a >= 0) begin
        exp_we_a = we[a]; exp_addr_a = addr[a*AW +: AW]; exp_data_a = wdata[a*DW +: DW];
      end
      if (b >= 0) begin
        exp_we_b = we[b]; exp_addr_b = addr[b*AW +: AW]; exp_data_b = wdata[b*DW +: DW];
      end
      for (int g = 0; g < NREQ; g++) begin
        if ((g == a || g == b) && !we[g]) exp_q[g].push_back('{data: shadow[addr_of(g)], due: cyc + 2});
      end
      for (int g = 0; g < NREQ; g++) begin
        if ((g == a || g == b) && we[g]) shadow[addr_of(g)] = wdata[g*DW +: DW];
      end
      if (a >= 0) m_rr = (((b >= 0) ? b : a) + 1) % NREQ;
      if (skipped && m_cnt < 255) m_cnt++;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  logic [DW-1:0] last_rd [NREQ];
  initial for (int i = 0; i < NREQ; i++) last_rd[i] = '0;
  always @(negedge clk) begin
    rd_t e;
    if (rst) begin
      check("rvalid_in_reset", rvalid, 0);
      for (int i = 0; i < NREQ; i++) begin
        exp_q[i].delete();
        last_rd[i] = '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (rvalid[i]) begin
          if (exp_q[i].size() == 0) begin
            check("rvalid_unexpected", rvalid[i], 0);
          end else begin
            e = exp_q[i].pop_front();
            check("rdata", rdata[i*DW +: DW], e.data);
            check("read_latency", cyc, e.due);
            last_rd[i] = e.data;
          end
        end else begin
          check("rdata_hold", rdata[i*DW +: DW], last_rd[i]);
        end
      end
    end
  end

  // Stimulus helpers. The driver always resumes just after a rising edge.
  task automatic tick(output logic [NREQ-1:0] g);
    @(negedge clk);
    g = gnt;
    @(posedge clk);
    #1;
    req = req & ~g;
  endtask

  task automatic set_req(input int i, input bit w, input int a, input int d);
    we[i]               = w;
    addr[i*AW +: AW]    = AW'(a);
    wdata[i*DW +: DW]   = DW'(d);
    req[i]              = 1'b1;
  endtask

  task automatic do_reset();
    logic [NREQ-1:0] g;
    req = '0;
    repeat (4) tick(g);
    rst = 1'b1;
    repeat (2) tick(g);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] g;
    int              cnt [NREQ];
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_conflict_cnt", conflict_cnt, 0);
    check("reset_mem_we", {mem_we_a, mem_we_b}, 0);
    check("reset_rdata", rdata, 0);
    check("reset_mem_addr", {mem_addr_a, mem_addr_b}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset while a read is in flight.
    set_req(1, 0, 4, 0);
    tick(g); check("t1_gnt", g, 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    check("t1_rvalid", rvalid, 0);
    check("t1_mem_we", {mem_we_a, mem_we_b}, 0);
    @(posedge clk); @(negedge clk);
    check("t1_rvalid_late", rvalid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 0, i, 0);
    tick(g); check("t1_rr_reset_gnt", g, 4'b0011);
    tick(g); check("t1_second_gnt", g, 4'b1100);

    // A write followed by a read of the same address in the next cycle.
    do_reset();
    set_req(0, 1, 3, 4'hA);
    set_req(1, 0, 5, 0);
    tick(g); check("t2_gnt0", g, 4'b0011);
    set_req(2, 0, 3, 0);
    tick(g); check("t2_gnt1", g, 4'b0100);
    tick(g);
    @(negedge clk);
    check("t2_rvalid2", rvalid[2], 1);
    check("t2_rdata2", rdata[2*DW +: DW], 4'hA);
    @(posedge clk); #1;

    // A write-write hazard skips req1, which wins on the following cycle.
    do_reset();
    set_req(0, 1, 2, 4'h3);
    set_req(1, 1, 2, 4'h6);
    set_req(2, 0, 6, 0);
    tick(g); check("t3_gnt0", g, 4'b0101);
    tick(g); check("t3_gnt1", g, 4'b0010);
    check("t3_conflict_cnt", conflict_cnt, 1);

    // Read-read to the same address on both ports.
    do_reset();
    set_req(0, 1, 7, 4'h5);
    tick(g);
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 7, 0);
    tick(g); check("t4_gnt0", g, 4'b0011);
    tick(g); check("t4_gnt1", g, 4'b1100);
    @(negedge clk);
    check("t4_rvalid0", rvalid, 4'b0011);
    check("t4_rdata0", rdata[0 +: 2*DW], 8'h55);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_rvalid1", rvalid, 4'b1100);
    check("t4_rdata1", rdata[2*DW +: 2*DW], 8'h55);
    @(posedge clk); #1;

    // Fairness with every requester held active.
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 0, i, 0);
      tick(g);
      for (int i = 0; i < NREQ; i++) if (g[i]) cnt[i]++;
    end
    req = '0;
    for (int i = 0; i < NREQ; i++) check("t5_fair_count", cnt[i], 4);

    // Counter saturation under continuous hazards.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      set_req(0, 1, 0, int'($urandom_range(15, 0)));
      set_req(1, 1, 0, int'($urandom_range(15, 0)));
      tick(g);
    end
    check("t6_saturated", conflict_cnt, 255);
    req = '0;
    repeat (3) tick(g);
    check("t6_saturated_hold", conflict_cnt, 255);
    do_reset();

    // Random traffic over a small address space so hazards are frequent.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && ($urandom_range(1, 0) == 1))
          set_req(i, bit'($urandom_range(1, 0)), int'($urandom_range(7, 0)), int'($urandom_range(15, 0)));
      end
      tick(g);
    end
    req = '0;
    repeat (6) tick(g);
    for (int i = 0; i < NREQ; i++) check("scoreboard_drained", exp_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
